// File: rtl/timer_mode_controller_if.sv
// Button, tick and preset inputs plus every observable output of the timer mode controller.
// The master side drives the buttons and tick; the slave side is the controller itself.
interface timer_mode_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             tick;
  logic             modeInput;
  logic             startOrStop;
  logic             splitOrReset;
  logic [CNT_W-1:0] presetValue;
  logic [1:0]       mode;
  logic [CNT_W-1:0] countValue;
  logic [CNT_W-1:0] lapValue;
  logic             lapValid;
  logic             timerRunning;
  logic             swRunning;
  logic [10:0]      alarmMinute;
  logic             alarmArmed;
  logic             ringSound;

  modport master (
    output tick, modeInput, startOrStop, splitOrReset, presetValue,
    input  mode, countValue, lapValue, lapValid, timerRunning, swRunning,
           alarmMinute, alarmArmed, ringSound
  );

  modport slave (
    input  tick, modeInput, startOrStop, splitOrReset, presetValue,
    output mode, countValue, lapValue, lapValid, timerRunning, swRunning,
           alarmMinute, alarmArmed, ringSound
  );
endinterface

// File: rtl/timer_mode_controller.sv
// Stopwatch/timer sequencer: button edge detection, 4-mode FSM, countdown, stopwatch with lap,
// time of day and alarm, with a single ring output.
module timer_mode_controller #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DAY_TICKS = 8640000,
  parameter int unsigned MIN_TICKS = 6000
) (
  input logic                   clockSignal,
  input logic                   resetSignalN,
  timer_mode_controller_if.slave bus
);

  typedef enum logic [1:0] {StTimer = 2'b00, StStopwatch = 2'b01, StClock = 2'b10,
                            StAlarmSet = 2'b11} mode_e;

  mode_e            mode_q, mode_d;
  logic [2:0]       btn_prev_q;
  logic [CNT_W-1:0] timer_q, timer_d, sw_q, sw_d, lap_q, lap_d;
  logic             lap_valid_q, lap_valid_d;
  logic             timer_run_q, timer_run_d, sw_run_q, sw_run_d;
  logic             armed_q, armed_d, ring_q, ring_d;
  logic [10:0]      alarm_min_q, alarm_min_d;
  logic [23:0]      tod_q, tod_d, alarm_ticks;
  logic             mode_ev, ss_ev, sr_ev, ss_act;
  logic [CNT_W-1:0] count_value;

  assign mode_ev     = bus.modeInput & ~btn_prev_q[2];
  assign ss_ev       = bus.startOrStop & ~btn_prev_q[1];
  assign sr_ev       = bus.splitOrReset & ~btn_prev_q[0];
  // A start/stop press while ringing is consumed by the dismiss.
  assign ss_act      = ss_ev & ~ring_q;
  assign alarm_ticks = 24'(alarm_min_q) * 24'(MIN_TICKS);

  always_comb begin
    mode_d      = mode_q;
    timer_d     = timer_q;
    sw_d        = sw_q;
    lap_d       = lap_q;
    lap_valid_d = 1'b0;
    timer_run_d = timer_run_q;
    sw_run_d    = sw_run_q;
    armed_d     = armed_q;
    ring_d      = ring_q;
    alarm_min_d = alarm_min_q;
    tod_d       = tod_q;

    if (mode_ev) mode_d = mode_e'(mode_q + 2'd1);
    if (ss_ev && ring_q) ring_d = 1'b0;

    // Buttons act on the mode in force before this edge; start/stop resolves before split.
    unique case (mode_q)
      StTimer: begin
        if (ss_act && (timer_q != '0)) timer_run_d = ~timer_run_q;
        if (sr_ev && !timer_run_d) timer_d = bus.presetValue;
      end
      StStopwatch: begin
        if (ss_act) sw_run_d = ~sw_run_q;
        if (sr_ev) begin
          if (sw_run_d) begin
            lap_d       = sw_q;
            lap_valid_d = 1'b1;
          end else begin
            sw_d = '0;
          end
        end
      end
      StClock: begin
      end
      StAlarmSet: begin
        if (sr_ev) alarm_min_d = (alarm_min_q == 11'd1439) ? 11'd0 : alarm_min_q + 11'd1;
        if (ss_act) armed_d = ~armed_q;
      end
      default: begin
      end
    endcase

    if (bus.tick) begin
      tod_d = (tod_q == 24'(DAY_TICKS - 1)) ? 24'd0 : tod_q + 24'd1;
      if (timer_run_d && (timer_d != '0)) begin
        timer_d = timer_d - CNT_W'(1);
        if (timer_d == '0) begin
          timer_run_d = 1'b0;
          ring_d      = 1'b1;
        end
      end
      if (sw_run_d) sw_d = sw_d + CNT_W'(1);
      if (armed_q && (tod_d == alarm_ticks)) ring_d = 1'b1;
    end
  end

  always_ff @(posedge clockSignal) begin
    if (!resetSignalN) begin
      mode_q      <= StTimer;
      btn_prev_q  <= '0;
      timer_q     <= '0;
      sw_q        <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      timer_run_q <= 1'b0;
      sw_run_q    <= 1'b0;
      armed_q     <= 1'b0;
      ring_q      <= 1'b0;
      alarm_min_q <= '0;
      tod_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      btn_prev_q  <= {bus.modeInput, bus.startOrStop, bus.splitOrReset};
      timer_q     <= timer_d;
      sw_q        <= sw_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      timer_run_q <= timer_run_d;
      sw_run_q    <= sw_run_d;
      armed_q     <= armed_d;
      ring_q      <= ring_d;
      alarm_min_q <= alarm_min_d;
      tod_q       <= tod_d;
    end
  end

  always_comb begin
    count_value = '0;
    unique case (mode_q)
      StTimer:     count_value = timer_q;
      StStopwatch: count_value = sw_q;
      StClock:     count_value = CNT_W'(tod_q);
      StAlarmSet:  count_value = CNT_W'(alarm_ticks);
      default:     count_value = '0;
    endcase
  end

  assign bus.mode         = mode_q;
  assign bus.countValue   = count_value;
  assign bus.lapValue     = lap_q;
  assign bus.lapValid     = lap_valid_q;
  assign bus.timerRunning = timer_run_q;
  assign bus.swRunning    = sw_run_q;
  assign bus.alarmMinute  = alarm_min_q;
  assign bus.alarmArmed   = armed_q;
  assign bus.ringSound    = ring_q;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed bench: stimulus pushes expected snapshots, laps and ring values into queues; a monitor
// on the falling edge pops and compares them when the DUT presents the matching output.
module tb_timer_mode_controller;
  localparam int unsigned CW = 32;
  localparam int unsigned DT = 16000;
  localparam int unsigned MT = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_mode_controller_if #(.CNT_W(CW)) bus ();

  timer_mode_controller #(.CNT_W(CW), .DAY_TICKS(DT), .MIN_TICKS(MT)) dut (
    .clockSignal (clk),
    .resetSignalN(rst_n),
    .bus         (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] cnt;
    logic [31:0] lap;
    logic        tr;
    logic        sw;
    logic [10:0] am;
    logic        armed;
    logic        ring;
  } snap_t;

  snap_t       exp_q[$];
  logic [31:0] lap_q[$];
  logic [31:0] ring_q[$];
  int checks = 0;
  int errors = 0;

  logic [1:0]  e_mode;
  logic [31:0] e_cnt, e_lap;
  logic        e_tr, e_sw, e_armed, e_ring;
  logic [10:0] e_am;
  int          tod_m = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n);
    snap_t s;
    s.name = n; s.mode = e_mode; s.cnt = e_cnt; s.lap = e_lap; s.tr = e_tr; s.sw = e_sw;
    s.am = e_am; s.armed = e_armed; s.ring = e_ring;
    exp_q.push_back(s);
  endtask

  task automatic press(input logic m, input logic s, input logic r);
    bus.modeInput = m; bus.startOrStop = s; bus.splitOrReset = r;
    cyc();
    bus.modeInput = 1'b0; bus.startOrStop = 1'b0; bus.splitOrReset = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    tod_m = (tod_m == int'(DT) - 1) ? 0 : tod_m + 1;
  endtask

  task automatic clear_exp();
    e_mode = 2'd0; e_cnt = '0; e_lap = '0; e_tr = 1'b0; e_sw = 1'b0;
    e_am = '0; e_armed = 1'b0; e_ring = 1'b0;
  endtask

  // Monitor
  initial begin
    snap_t       s;
    logic [31:0] v;
    logic        ring_prev;
    ring_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        checks++;
        if ({bus.mode, bus.countValue, bus.lapValue, bus.timerRunning, bus.swRunning,
             bus.alarmMinute, bus.alarmArmed, bus.ringSound} !==
            {s.mode, s.cnt, s.lap, s.tr, s.sw, s.am, s.armed, s.ring}) begin
          errors++;
          $display("FAIL %s: got mode=%0d cnt=%0d lap=%0d tr=%0b sw=%0b am=%0d armed=%0b ring=%0b; expected mode=%0d cnt=%0d lap=%0d tr=%0b sw=%0b am=%0d armed=%0b ring=%0b",
                   s.name, bus.mode, bus.countValue, bus.lapValue, bus.timerRunning,
                   bus.swRunning, bus.alarmMinute, bus.alarmArmed, bus.ringSound,
                   s.mode, s.cnt, s.lap, s.tr, s.sw, s.am, s.armed, s.ring);
        end
      end
      if (bus.lapValid === 1'b1) begin
        checks++;
        if (lap_q.size() == 0) begin
          errors++;
          $display("FAIL lap_pulse: unexpected lapValid, lapValue=%0d", bus.lapValue);
        end else begin
          v = lap_q.pop_front();
          if (bus.lapValue !== v) begin
            errors++;
            $display("FAIL lap_value: got %0d expected %0d", bus.lapValue, v);
          end
        end
      end
      if ((bus.ringSound === 1'b1) && !ring_prev) begin
        checks++;
        if (ring_q.size() == 0) begin
          errors++;
          $display("FAIL ring_rise: unexpected ring, countValue=%0d", bus.countValue);
        end else begin
          v = ring_q.pop_front();
          if (bus.countValue !== v) begin
            errors++;
            $display("FAIL ring_rise: countValue got %0d expected %0d", bus.countValue, v);
          end
        end
      end
      ring_prev = (bus.ringSound === 1'b1);
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_exp();
    bus.tick = 1'b0; bus.presetValue = '0;
    bus.modeInput = 1'b1; bus.startOrStop = 1'b1; bus.splitOrReset = 1'b1;
    rst_n = 1'b0;
    cyc(); cyc();
    chk("reset");
    bus.modeInput = 1'b0; bus.startOrStop = 1'b0; bus.splitOrReset = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_reset");

    // Countdown to ring, dismiss, start ignored at zero
    bus.presetValue = 32'd3;
    press(0, 0, 1); e_cnt = 32'd3; chk("timer_load");
    press(0, 1, 0); e_tr = 1'b1; chk("timer_start");
    do_tick(); e_cnt = 32'd2; chk("timer_t1");
    do_tick(); e_cnt = 32'd1; chk("timer_t2");
    ring_q.push_back(32'd0);
    do_tick(); e_cnt = 32'd0; e_tr = 1'b0; e_ring = 1'b1; chk("timer_expire");
    press(0, 1, 0); e_ring = 1'b0; chk("timer_dismiss");
    press(0, 1, 0); chk("start_at_zero");

    // Stopwatch with lap
    press(1, 0, 0); e_mode = 2'd1; e_cnt = 32'd0; chk("mode_sw");
    press(0, 1, 0); e_sw = 1'b1; chk("sw_start");
    for (int i = 0; i < 5; i++) do_tick();
    e_cnt = 32'd5; chk("sw_count5");
    lap_q.push_back(32'd5);
    press(0, 0, 1); e_lap = 32'd5; chk("sw_lap");
    press(0, 1, 0); e_sw = 1'b0; chk("sw_stop");
    press(0, 0, 1); e_cnt = 32'd0; chk("sw_clear");

    // Mode wrap while the timer runs in the background
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    e_mode = 2'd0; e_cnt = 32'd0; chk("mode_to_timer");
    bus.presetValue = 32'd100;
    press(0, 0, 1); e_cnt = 32'd100;
    press(0, 1, 0); e_tr = 1'b1; chk("timer100_run");
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (i % 3 == 0) press(1, 0, 0);
    end
    e_cnt = 32'd90; chk("mode_wrap_bg");
    press(0, 1, 0); e_tr = 1'b0; chk("timer_stop90");
    bus.presetValue = 32'd7;
    press(0, 1, 1); e_tr = 1'b1; chk("start_plus_load");
    press(0, 1, 0); e_tr = 1'b0; chk("timer_stop_again");

    // Alarm set, arm, ring at minute 2, held dismiss
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    e_mode = 2'd3; e_cnt = 32'd0; chk("mode_alarm");
    press(0, 0, 1); press(0, 0, 1);
    e_am = 11'd2; e_cnt = 32'd12000; chk("alarm_min2");
    press(0, 1, 0); e_armed = 1'b1; chk("alarm_arm");
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    e_mode = 2'd2; e_cnt = 32'(tod_m); chk("clock_view");
    press(0, 0, 1); chk("clock_split_noop");
    ring_q.push_back(32'd12000);
    while (tod_m < 12000) do_tick();
    e_cnt = 32'd12000; e_ring = 1'b1; chk("alarm_ring");
    bus.startOrStop = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    bus.startOrStop = 1'b0;
    cyc();
    e_ring = 1'b0; chk("hold_dismiss");

    // Alarm minute wrap and time-of-day wrap, which also matches minute 0
    press(1, 0, 0); e_mode = 2'd3;
    for (int i = 0; i < 1437; i++) press(0, 0, 1);
    e_am = 11'd1439; e_cnt = 32'd8634000; chk("alarm_1439");
    press(0, 0, 1); e_am = 11'd0; e_cnt = 32'd0; chk("alarm_wrap");
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    e_mode = 2'd2; e_cnt = 32'd12000; chk("clock_view2");
    while (tod_m != int'(DT) - 1) do_tick();
    e_cnt = 32'(DT - 1); chk("tod_last");
    ring_q.push_back(32'd0);
    do_tick(); e_cnt = 32'd0; e_ring = 1'b1; chk("tod_wrap_ring");
    press(0, 1, 0); e_ring = 1'b0; chk("dismiss2");

    // Reset in the middle of a countdown, with buttons and tick active
    press(1, 0, 0); press(1, 0, 0);
    e_mode = 2'd0; e_cnt = 32'd90; chk("back_to_timer");
    press(0, 1, 0); e_tr = 1'b1;
    do_tick(); e_cnt = 32'd89; chk("timer_89");
    bus.tick = 1'b1; bus.startOrStop = 1'b1; bus.splitOrReset = 1'b1;
    rst_n = 1'b0;
    cyc();
    clear_exp(); chk("reset_mid_count");
    bus.tick = 1'b0; bus.startOrStop = 1'b0; bus.splitOrReset = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("after_reset2");

    cyc(); cyc();
    checks++;
    if ((exp_q.size() != 0) || (lap_q.size() != 0) || (ring_q.size() != 0)) begin
      errors++;
      $display("FAIL queues_drained: snap=%0d lap=%0d ring=%0d left, expected 0 0 0",
               exp_q.size(), lap_q.size(), ring_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_mode_controller.md
Name: timer_mode_controller

Overview:
Central sequencer for the stopwatch/timer product. Converts the three raw user buttons into rising-edge events and runs the 4-mode state machine: countdown timer, stopwatch with lap, time-of-day view, and alarm set. Owns the timer, stopwatch, time-of-day and alarm registers, and drives ringSound. The display/formatting blocks downstream consume its outputs.

Parameters:
CNT_W, 32, width of the timer and stopwatch counters (centisecond units)
DAY_TICKS, 8640000, centiseconds per day; timeOfDay wraps here
MIN_TICKS, 6000, centiseconds per minute; scales the alarm minute

Ports:
clockSignal  in  1  system clock
resetSignalN  in  1  synchronous reset, active-low
tick  in  1  one-cycle enable, one pulse per centisecond
modeInput  in  1  raw mode button, level, already synchronised
startOrStop  in  1  raw start/stop/dismiss button, level
splitOrReset  in  1  raw split/reset/adjust button, level
presetValue  in  CNT_W  countdown load value in centiseconds
mode  out  2  00 TIMER, 01 STOPWATCH, 10 CLOCK, 11 ALARM_SET
countValue  out  CNT_W  value selected by mode (see below)
lapValue  out  CNT_W  last captured stopwatch lap
lapValid  out  1  one-cycle pulse when lapValue updates
timerRunning  out  1  countdown active
swRunning  out  1  stopwatch active
alarmMinute  out  11  alarm time, minutes since midnight, 0..1439
alarmArmed  out  1  alarm enabled
ringSound  out  1  alarm/timer ringing

Behaviour:
- Every button is registered into a prev flop each cycle. Event = level & ~prev. An action takes effect at the clock edge on which the event is true. Output changes one cycle after the input first samples high. Holding a button yields exactly one event.
- Reset (resetSignalN=0 at clock edge) sets: mode=00, all counters 0, timeOfDay=0, lapValue=0, lapValid=0, timerRunning=0, swRunning=0, alarmMinute=0, alarmArmed=0, ringSound=0, prev flops=0. Reset wins over every other event, including mid-countdown.
- Mode FSM: a modeInput event advances 00->01->10->11->00. No other effect. Running timer and stopwatch continue in the background.
- Dismiss priority: if ringSound=1, a startOrStop event clears ringSound and is consumed, with no mode action that cycle.
- TIMER (00):
  - startOrStop event toggles timerRunning, but only if timerCount!=0; otherwise it is ignored.
  - splitOrReset event while stopped loads timerCount=presetValue. It is ignored while running.
  - On tick with timerRunning: decrement. On the 1->0 step, same edge: timerRunning=0, ringSound=1.
- STOPWATCH (01):
  - startOrStop event toggles swRunning.
  - splitOrReset event while running: lapValue=swCount (pre-increment value if tick coincides), lapValid pulses 1 cycle.
  - splitOrReset event while stopped: swCount=0.
  - On tick with swRunning: swCount+1, wrapping at 2^CNT_W to 0.
- CLOCK (10): buttons have no effect except dismiss.
- ALARM_SET (11):
  - splitOrReset event: alarmMinute+1, wrapping 1439->0.
  - startOrStop event toggles alarmArmed.
- timeOfDay (24-bit) increments on every tick in every mode, wrapping DAY_TICKS-1 -> 0.
- Alarm match: on the tick edge where the new timeOfDay equals alarmMinute*MIN_TICKS and alarmArmed=1, ringSound=1. It fires once per day and does not disarm.
- ringSound stays 1 until dismissed or reset. A second ring source while ringing has no further effect.
- countValue mux: 00 timerCount, 01 swCount, 10 timeOfDay zero-extended, 11 alarmMinute*MIN_TICKS zero-extended. The mux is combinational from registers.
- Simultaneous events in the same cycle:
  - The mode event is applied, and the other buttons act on the old mode.
  - startOrStop is processed before splitOrReset. In TIMER this means a simultaneous start plus load leaves the timer stopped-then-running, and the load is ignored.

Test Plan:
- Reset: hold resetSignalN=0 for 2 cycles with buttons high -> all outputs 0; releasing the buttons produces no events.
- Timer: presetValue=3; press split, then start; give 3 ticks -> countValue 3,2,1,0; ringSound=1 on the third tick edge; timerRunning=0. Press start -> ringSound=0 and timerRunning stays 0.
- Stopwatch lap: mode once to reach 01; start; 5 ticks; split -> lapValue=5, lapValid high for exactly 1 cycle. Stop, then split -> countValue=0.
- Mode wrap and background run: timer running with preset 100; press mode 4 times during 10 ticks -> mode back to 00, countValue=90.
- Alarm: enter 11; split x2 -> alarmMinute=2; start -> alarmArmed=1; run 12000 ticks -> ringSound rises exactly at timeOfDay=12000. Hold startOrStop high for many cycles -> a single dismiss, alarmArmed unchanged.
- Wraps: alarmMinute at 1439 plus split -> 0. Force timeOfDay to DAY_TICKS-1 via ticks, then one tick -> 0.
